// File: rtl/eth_rx_filter_pkg.sv
// Shared types and constants for the receive-path destination-MAC filter.
package eth_rx_filter_pkg;

    localparam int              ETH_ADDR_W        = 48;
    localparam logic [47:0]     ETH_BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;
    localparam int              ETH_HDR_DST_BYTES = 6;

    typedef enum logic [1:0] {
        HDR,
        EMIT,
        PASS,
        DROP
    } filt_state_t;

    // Byte 0 is the first byte on the wire, i.e. dst[47:40].
    function automatic logic [7:0] dst_byte(input logic [ETH_ADDR_W-1:0] dst,
                                            input logic [2:0]            idx);
        case (idx)
            3'd0:    dst_byte = dst[47:40];
            3'd1:    dst_byte = dst[39:32];
            3'd2:    dst_byte = dst[31:24];
            3'd3:    dst_byte = dst[23:16];
            3'd4:    dst_byte = dst[15:8];
            3'd5:    dst_byte = dst[7:0];
            default: dst_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/eth_dst_addr_match.sv
// Combinational accept decision for a buffered destination address.
module eth_dst_addr_match
    import eth_rx_filter_pkg::*;
(
    input  logic [ETH_ADDR_W-1:0] dst,
    input  logic [ETH_ADDR_W-1:0] local_mac,
    input  logic                  promisc,
    input  logic                  mcast_en,
    output logic                  match
);

    // dst[40] is the group bit of the first octet on the wire.
    assign match = promisc
                 | (dst == local_mac)
                 | (dst == ETH_BCAST_ADDR)
                 | (mcast_en & dst[40]);

endmodule

// File: rtl/eth_rx_dest_filter.sv
// Buffers the destination MAC of each RX frame, then forwards or discards it.
// Optional statistics counters are enabled with ETH_RX_FILTER_STATS_EN.
module eth_rx_dest_filter
    import eth_rx_filter_pkg::*;
#(
    parameter int HDR_BYTES = ETH_HDR_DST_BYTES
) (
    input  logic                  logic_clk,
    input  logic                  logic_rst,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic [ETH_ADDR_W-1:0] local_mac,
    input  logic                  promisc,
    input  logic                  mcast_en,
`ifdef ETH_RX_FILTER_STATS_EN
    output logic [31:0]           stat_pass_cnt,
    output logic [31:0]           stat_drop_cnt,
    output logic [31:0]           stat_runt_cnt,
`endif
    output logic                  frame_pass,
    output logic                  frame_drop
);

    localparam logic [2:0] LAST_IDX = 3'(HDR_BYTES - 1);

    filt_state_t           r_state;
    logic [2:0]            r_idx;
    logic [ETH_ADDR_W-1:0] r_dst;
    logic                  r_last6;
    logic                  r_user6;
    logic                  r_pass;
    logic                  r_drop;

    filt_state_t           w_state_next;
    logic [2:0]            w_idx_next;
    logic [ETH_ADDR_W-1:0] w_dst_next;
    logic                  w_last6_next;
    logic                  w_user6_next;
    logic                  w_pass_next;
    logic                  w_drop_next;
    logic                  w_runt;
    logic [ETH_ADDR_W-1:0] w_dst_shift;
    logic                  w_match;

    // The decision must see the sixth byte before it lands in r_dst.
    assign w_dst_shift = {r_dst[ETH_ADDR_W-9:0], s_axis_tdata};

    eth_dst_addr_match u_match (
        .dst       (w_dst_shift),
        .local_mac (local_mac),
        .promisc   (promisc),
        .mcast_en  (mcast_en),
        .match     (w_match)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_dst_next    = r_dst;
        w_last6_next  = r_last6;
        w_user6_next  = r_user6;
        w_pass_next   = 1'b0;
        w_drop_next   = 1'b0;
        w_runt        = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;

        case (r_state)
            HDR: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    w_dst_next = w_dst_shift;
                    w_idx_next = r_idx + 3'd1;
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = 3'd0;
                        w_last6_next = s_axis_tlast;
                        w_user6_next = s_axis_tuser;
                        if (w_match) begin
                            w_pass_next  = 1'b1;
                            w_state_next = EMIT;
                        end else begin
                            w_drop_next = 1'b1;
                            if (!s_axis_tlast) w_state_next = DROP;
                        end
                    end else if (s_axis_tlast) begin
                        w_idx_next  = 3'd0;
                        w_drop_next = 1'b1;
                        w_runt      = 1'b1;
                    end
                end
            end
            EMIT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = dst_byte(r_dst, r_idx);
                if (r_idx == LAST_IDX) begin
                    m_axis_tlast = r_last6;
                    m_axis_tuser = r_user6;
                end
                if (m_axis_tready) begin
                    w_idx_next = r_idx + 3'd1;
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = 3'd0;
                        w_state_next = r_last6 ? HDR : PASS;
                    end
                end
            end
            PASS: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) w_state_next = HDR;
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) w_state_next = HDR;
            end
            default: w_state_next = HDR;
        endcase
    end

    always_ff @(posedge logic_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (logic_rst) begin
            r_state <= HDR;
            r_idx   <= 3'd0;
            r_dst   <= '0;
            r_last6 <= 1'b0;
            r_user6 <= 1'b0;
            r_pass  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_dst   <= w_dst_next;
            r_last6 <= w_last6_next;
            r_user6 <= w_user6_next;
            r_pass  <= w_pass_next;
            r_drop  <= w_drop_next;
        end
    end

    assign frame_pass = r_pass;
    assign frame_drop = r_drop;

`ifdef ETH_RX_FILTER_STATS_EN
    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            stat_pass_cnt <= '0;
            stat_drop_cnt <= '0;
            stat_runt_cnt <= '0;
        end else begin
            if (w_pass_next)            stat_pass_cnt <= stat_pass_cnt + 32'd1;
            if (w_drop_next && !w_runt) stat_drop_cnt <= stat_drop_cnt + 32'd1;
            if (w_drop_next && w_runt)  stat_runt_cnt <= stat_runt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/eth_rx_dest_filter.md
# eth_rx_dest_filter

Destination-MAC filter on the receive path, in the `logic_clk` domain directly downstream of the 1G RGMII MAC's RX FIFO output (`rx_axis_*`, 8-bit). It holds the first 6 bytes of each frame and compares the destination address against the local MAC, broadcast and multicast rules. Matching frames are forwarded unchanged on an output AXI-Stream. Non-matching and runt frames are consumed and discarded, with a per-frame drop pulse.

## Interface
Parameters:
- `HDR_BYTES`, default 6: destination-address bytes buffered before the decision; fixed at 6 in this revision.

Ports:
- `logic_clk`  in  1  block clock.
- `logic_rst`  in  1  reset; synchronous to `logic_clk`, active-high.
- `s_axis_tdata`  in  8  input frame byte; the first byte is `dst[47:40]`.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `s_axis_tlast`  in  1  last byte of the frame.
- `s_axis_tuser`  in  1  bad-frame flag; meaningful only on `tlast`.
- `m_axis_tdata`  out  8  output byte.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tlast`  out  1  output last.
- `m_axis_tuser`  out  1  output bad-frame flag.
- `local_mac`  in  48  station address; must be held stable while frames are in flight.
- `promisc`  in  1  accept all frames of at least 6 bytes.
- `mcast_en`  in  1  accept frames whose `dst[40]` = 1.
- `frame_pass`  out  1  one-cycle pulse when a frame is accepted.
- `frame_drop`  out  1  one-cycle pulse when a frame is discarded (mismatch or runt).

## Operation
- **States:** HDR, EMIT, PASS, DROP. Reset puts the block in HDR with byte index 0.
- **HDR**
  - `s_axis_tready` = 1 and `m_axis_tvalid` = 0.
  - Each accepted byte is shifted into `dst_r[47:0]`, MSB first, and the index increments.
  - **Runt frame:** `tlast` accepted with index < 5. Pulse `frame_drop`, reset the index, stay in HDR. Nothing is output.
  - **Sixth byte (index 5):** evaluate `match = promisc | (dst == local_mac) | (dst == 48'hFFFF_FFFF_FFFF) | (mcast_en & dst[40])`, using the combined value including the current byte. Latch `last6 = tlast` and `user6 = tuser`.
    - If match: pulse `frame_pass` and go to EMIT.
    - If not match and `tlast` = 1: pulse `frame_drop` and stay in HDR.
    - If not match and `tlast` = 0: pulse `frame_drop` and go to DROP.
- **EMIT**
  - `s_axis_tready` = 0 and `m_axis_tvalid` = 1.
  - Outputs `dst_r` bytes 0..5 in order, advancing on `m_axis_tready`.
  - Byte 5 carries `tlast = last6` and `tuser = user6`; all other bytes carry `tlast` = 0 and `tuser` = 0.
  - After byte 5 is taken: go to HDR if `last6` = 1, otherwise go to PASS.
- **PASS**
  - Combinational pass-through: `m_axis_* = s_axis_*` and `s_axis_tready = m_axis_tready`.
  - A transfer with `tlast` returns the block to HDR.
- **DROP**
  - `s_axis_tready` = 1 and `m_axis_tvalid` = 0.
  - An accepted `tlast` returns the block to HDR.
- `tuser` is never interpreted. Bad frames that match are forwarded with `tuser` intact for downstream handling.

## Timing
- Reset values: `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tuser` = 0, `m_axis_tdata` = 0, `frame_pass` = 0, `frame_drop` = 0. `s_axis_tready` = 1, since the block resets into HDR.
- **Latency:** the first output byte is valid on the cycle after the 6th input byte is accepted. After the header, PASS adds zero cycles.
- **Stall:** EMIT applies 6 cycles of backpressure on `s_axis` per accepted frame, assuming `m_axis_tready` = 1.
- Decision pulses are registered and occur on the cycle after the deciding byte is accepted.
- **AXI-Stream rules:** `m_axis_tvalid` never drops without a handshake, and data is held stable while stalled.
- **Reset mid-frame:** the partial frame is abandoned with no `tlast` emitted, and the remainder of that frame's input is treated as a new frame. Upstream is reset together with this block.

## Configuration
- `ETH_RX_FILTER_STATS_EN` defined: adds three 32-bit output counters.
  - `stat_pass_cnt` increments on `frame_pass`.
  - `stat_drop_cnt` increments on a mismatch `frame_drop`.
  - `stat_runt_cnt` increments on a runt `frame_drop`.
  - All three are cleared by `logic_rst` and wrap modulo 2^32.
- Not defined: the counter ports and logic are absent. The pulse outputs remain.

## Structure
- Package `eth_rx_filter_pkg`: state enum (`HDR`, `EMIT`, `PASS`, `DROP`), `ETH_ADDR_W` = 48, `ETH_BCAST_ADDR` = 48'hFFFF_FFFF_FFFF, `ETH_HDR_DST_BYTES` = 6.
- One sub-module, `eth_dst_addr_match`: purely combinational, inputs `dst`, `local_mac`, `promisc`, `mcast_en`, output `match`.

## Test plan
- Frame of 64 bytes with dst = `local_mac` = 02:00:00:00:00:01 and `m_axis_tready` = 1 -> 64 bytes output, identical in content; `frame_pass` pulses once; `tlast` on byte 63.
- Frame with dst = 02:00:00:00:00:02, `promisc` = 0, `mcast_en` = 0 -> no output; `frame_drop` pulses once; `s_axis_tready` stays 1 for all 64 bytes.
- Broadcast FF:FF:FF:FF:FF:FF frame, then a 01:00:5E:00:00:01 frame with `mcast_en` = 0 -> first forwarded, second dropped. Repeat with `mcast_en` = 1 -> both forwarded.
- 4-byte runt with `tlast` on byte 3 -> no output and `frame_drop` pulses; a following matching frame passes intact.
- Exactly 6-byte matching frame with `tuser` = 1, and `m_axis_tready` toggling every other cycle -> 6 bytes output; byte 5 has `tlast` = 1 and `tuser` = 1; no data is lost or duplicated.
- `logic_rst` asserted at byte 20 of a passing frame -> outputs return to reset values on the next cycle; the next matching frame is forwarded correctly. With `ETH_RX_FILTER_STATS_EN` defined, the counters read 0 after reset.
